// File: rtl/univ_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_reg
// Brief    : WIDTH-bit universal register. Modes: hold, load, shift, rotate,
//            increment and decrement. Outputs a registered carry/shift-out flag
//            and a combinational zero flag.
// Revision : 1.0 - initial release
// ============================================================================
module univ_reg #(
  parameter int WIDTH   = 8,
  parameter     RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             sin_l_i,
  input  logic             sin_r_i,
  output logic [WIDTH-1:0] q_o,
  output logic             cout_o,
  output logic             zero_o
);

  localparam logic [2:0] C_HOLD = 3'd0;
  localparam logic [2:0] C_LOAD = 3'd1;
  localparam logic [2:0] C_SHL  = 3'd2;
  localparam logic [2:0] C_SHR  = 3'd3;
  localparam logic [2:0] C_ROL  = 3'd4;
  localparam logic [2:0] C_ROR  = 3'd5;
  localparam logic [2:0] C_INC  = 3'd6;
  localparam logic [2:0] C_DEC  = 3'd7;

  // The cast truncates or zero-extends RST_VAL to WIDTH bits.
  localparam logic [WIDTH-1:0] C_RST_VAL = WIDTH'(RST_VAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;

  always_comb begin
    q_d    = q_q;
    cout_d = cout_q;
    if (en_i) begin
      case (mode_i)
        C_HOLD: begin
          q_d    = q_q;
          cout_d = cout_q;
        end
        C_LOAD: begin
          q_d    = d_i;
          cout_d = 1'b0;
        end
        C_SHL: begin
          q_d    = {q_q[WIDTH-2:0], sin_l_i};
          cout_d = q_q[WIDTH-1];
        end
        C_SHR: begin
          q_d    = {sin_r_i, q_q[WIDTH-1:1]};
          cout_d = q_q[0];
        end
        C_ROL: begin
          q_d    = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
          cout_d = q_q[WIDTH-1];
        end
        C_ROR: begin
          q_d    = {q_q[0], q_q[WIDTH-1:1]};
          cout_d = q_q[0];
        end
        C_INC: begin
          q_d    = q_q + 1'b1;
          cout_d = &q_q;
        end
        C_DEC: begin
          q_d    = q_q - 1'b1;
          cout_d = ~|q_q;
        end
        default: begin
          q_d    = q_q;
          cout_d = cout_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q    <= C_RST_VAL;
      cout_q <= 1'b0;
    end else begin
      q_q    <= q_d;
      cout_q <= cout_d;
    end
  end

  assign q_o    = q_q;
  assign cout_o = cout_q;
  assign zero_o = ~|q_q;

endmodule
`default_nettype wire

// File: tb/tb_univ_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_reg
// Brief    : Self-checking bench for univ_reg (WIDTH=8, RST_VAL=8'hA5).
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_reg;

  localparam int C_W = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           en_i = 1'b0;
  logic [2:0]     mode_i = 3'd0;
  logic [C_W-1:0] d_i = '0;
  logic           sin_l_i = 1'b0;
  logic           sin_r_i = 1'b0;
  logic [C_W-1:0] q_o;
  logic           cout_o;
  logic           zero_o;

  univ_reg #(.WIDTH(C_W), .RST_VAL(8'hA5)) dut (
    .clk     (clk),
    .rst     (rst),
    .en_i    (en_i),
    .mode_i  (mode_i),
    .d_i     (d_i),
    .sin_l_i (sin_l_i),
    .sin_r_i (sin_r_i),
    .q_o     (q_o),
    .cout_o  (cout_o),
    .zero_o  (zero_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sl;
    logic       sr;
    logic [7:0] eq;
    logic       ec;
    logic       ez;
  } vec_t;

  localparam int C_NV = 26;
  vec_t vecs [C_NV];

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state, computed arithmetically from the mode rules.
  int mq = 0;
  int mc = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic e, input logic [2:0] m,
                            input logic [7:0] d, input logic sl, input logic sr);
    if (r) begin
      mq = 8'hA5;
      mc = 0;
    end else if (e) begin
      case (m)
        3'd0: ;
        3'd1: begin mq = int'(d); mc = 0; end
        3'd2: begin mc = mq / 128; mq = (mq * 2) % 256 + int'(sl); end
        3'd3: begin mc = mq % 2;   mq = int'(sr) * 128 + mq / 2; end
        3'd4: begin mc = mq / 128; mq = (mq * 2) % 256 + mc; end
        3'd5: begin mc = mq % 2;   mq = mc * 128 + mq / 2; end
        3'd6: begin mc = (mq == 255) ? 1 : 0; mq = (mq + 1) % 256; end
        default: begin mc = (mq == 0) ? 1 : 0; mq = (mq + 255) % 256; end
      endcase
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [2:0] m,
                      input logic [7:0] d, input logic sl, input logic sr);
    @(negedge clk);
    rst = r; en_i = e; mode_i = m; d_i = d; sin_l_i = sl; sin_r_i = sr;
    @(posedge clk);
    model_step(r, e, m, d, sl, sr);
    #1;
    // Scramble inputs away from the edge; only edge-sampled values may matter.
    mode_i = 3'($urandom); d_i = 8'($urandom);
    sin_l_i = 1'($urandom); sin_r_i = 1'($urandom);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q"},    q_o,           8'(mq));
    check({tag, "_cout"}, {7'd0, cout_o}, 8'(mc));
    check({tag, "_zero"}, {7'd0, zero_o}, {7'd0, (mq == 0)});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            rst   en    mode  d      sl    sr    q      c     z
    vecs[0]  = '{1'b1, 1'b1, 3'd1, 8'hFF, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd2, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 3'd3, 8'h00, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 3'd1, 8'h81, 1'b0, 1'b0, 8'h81, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 3'd5, 8'h00, 1'b0, 1'b0, 8'hC0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 3'd4, 8'h00, 1'b0, 1'b0, 8'h81, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 3'd1, 8'hFE, 1'b0, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[10] = '{1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 3'd1, 8'h10, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 3'd6, 8'h00, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 3'd1, 8'h05, 1'b0, 1'b0, 8'h05, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'h06, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0, 8'hA6, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 8'hA6, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b1, 3'd1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[22] = '{1'b0, 1'b1, 3'd7, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[23] = '{1'b0, 1'b1, 3'd0, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[24] = '{1'b0, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b0, 8'hFF, 1'b1, 1'b0};
    vecs[25] = '{1'b1, 1'b0, 3'd1, 8'h3C, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};

    for (int i = 0; i < C_NV; i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].sl, vecs[i].sr);
      check($sformatf("vec%0d_q", i),    q_o,             vecs[i].eq);
      check($sformatf("vec%0d_cout", i), {7'd0, cout_o},  {7'd0, vecs[i].ec});
      check($sformatf("vec%0d_zero", i), {7'd0, zero_o},  {7'd0, vecs[i].ez});
    end

    // A reset pulse that does not span a rising edge must be ignored.
    step(1'b0, 1'b1, 3'd1, 8'h5A, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b0; en_i = 1'b1; mode_i = 3'd6;
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    model_step(1'b0, 1'b1, 3'd6, 8'h00, 1'b0, 1'b0);
    #1;
    check("glitch_rst_q", q_o, 8'h5B);
    check_model("glitch_rst");

    // Randomised run against the reference model.
    for (int i = 0; i < 400; i++) begin
      logic       r;
      logic       e;
      logic [2:0] m;
      logic [7:0] d;
      r = ($urandom_range(0, 31) == 0);
      e = ($urandom_range(0, 7) != 0);
      m = 3'($urandom);
      d = ($urandom_range(0, 5) == 0) ? 8'hFF : 8'($urandom);
      step(r, e, m, d, 1'($urandom), 1'($urandom));
      check_model($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/univ_reg.md
Name: univ_reg

Overview:
- Parametrised universal register, the successor to the single-bit D flip-flop cells.
- One WIDTH-bit register with a synchronous active-high reset to a programmable value and a clock enable.
- Eight operating modes: hold, parallel load, logical shift left/right with serial inputs, rotate left/right, increment and decrement.
- Produces a registered carry/shift-out flag and a combinational zero flag.
- Used as a building block for counters, shifters and data holding registers in the lab datapaths.

Parameters:
- WIDTH, 8, register width in bits; legal range is 2 or more.
- RST_VAL, 0, value loaded into q on reset; the implementation truncates or zero-extends it to WIDTH bits.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  clock enable; 0 means q and cout hold regardless of mode.
- mode  input  3  operation select: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 INC, 7 DEC.
- d  input  WIDTH  parallel load data.
- sin_l  input  1  serial input; enters q[0] on SHL.
- sin_r  input  1  serial input; enters q[WIDTH-1] on SHR.
- q  output  WIDTH  register contents, registered.
- cout  output  1  carry/shift-out flag, registered.
- zero  output  1  combinational; high when q == 0.

Behaviour:
- Priority at each rising clk edge: rst > en=0 > mode.
- Reset:
  - rst=1 sets q <= RST_VAL and cout <= 0 on the next edge, independent of en and mode.
  - Asynchronous rst pulses that do not span an edge have no effect.
  - rst asserted mid-operation, for example during an INC sequence, aborts it; the next cycle starts from RST_VAL.
- en=0: q and cout are unchanged.
- en=1, q' and cout' by mode:
  - HOLD: q'=q; cout'=cout.
  - LOAD: q'=d; cout'=0.
  - SHL: q'={q[WIDTH-2:0], sin_l}; cout'=q[WIDTH-1].
  - SHR: q'={sin_r, q[WIDTH-1:1]}; cout'=q[0].
  - ROL: q'={q[WIDTH-2:0], q[WIDTH-1]}; cout'=q[WIDTH-1].
  - ROR: q'={q[0], q[WIDTH-1:1]}; cout'=q[0].
  - INC: q'=q+1 modulo 2^WIDTH; cout'=1 exactly when q was all ones (wrap to 0), otherwise 0.
  - DEC: q'=q-1 modulo 2^WIDTH; cout'=1 exactly when q was 0 (borrow, wrap to all ones), otherwise 0.
- Latency: every operation is visible on q and cout one cycle after the enabling edge.
- zero follows q combinationally within the same cycle.
- Arithmetic is unsigned with WIDTH-bit wrap-around; no saturation.
- mode, d, sin_l and sin_r are sampled only at the edge; changes between edges have no effect.
- There is no reachable X state. After reset, q is always defined. Before the first reset, q is unknown and is not checked.

Test Plan:
- WIDTH=8, RST_VAL=8'hA5: assert rst for 1 cycle with en=1, mode=LOAD, d=8'hFF -> q=8'hA5, cout=0, zero=0.
- LOAD d=8'h81, then SHL with sin_l=1 -> q=8'h03, cout=1. Then SHR with sin_r=0 -> q=8'h01, cout=1.
- LOAD 8'h81, then ROR -> q=8'hC0, cout=1. Then ROL -> q=8'h81, cout=1.
- LOAD 8'hFE, then INC x2 -> q=8'hFF with cout=0, then q=8'h00 with cout=1 and zero=1. Then DEC -> q=8'hFF, cout=1.
- LOAD 8'h10, then en=0 with mode=INC for 3 cycles -> q stays 8'h10 and cout stays 0. Then en=1 and INC -> q=8'h11.
- During INC counting from 8'h05, assert rst in the same cycle as en=1, mode=INC -> q=8'hA5 (not 8'h06), cout=0. Counting resumes from 8'hA5 afterwards.
